instr_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS datapath: holds the program counter, issues requests to instruction memory, and presents the fetched word in an IF/ID register. The decode-side field outputs drive the main control decoder and register file directly. It sits upstream of the control decoder. It handles variable-latency memory, decode stalls and taken-branch redirects with flush.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/if_id_reg.sv | 37 +++
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants: opcodes, field positions, fetch states
package mips_pkg;

  // Primary opcodes recognised by the control decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Fetch FSM encoding
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Sequential PC step
  localparam logic [31:0] PC_INC = 32'd4;

  // Clear the byte-offset bits of an address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // Flush only kills validity; a load captures a new live instruction; otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, imem request, skid buffer, IF/ID
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;

  logic        ifid_load;
  logic        ifid_flush;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;

  assign pc_inc         = pc_q + PC_INC;
  assign target_aligned = word_align(branch_target);

  // Next-state decode: redirect beats everything, then per-state fetch/stall handling
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc4     = pc_inc;

    if (branch_taken) begin
      // Any word returned this cycle belongs to the wrong path and is dropped
      pc_d         = target_aligned;
      ifid_flush   = 1'b1;
      skid_valid_d = 1'b0;
      state_d      = ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_inc;
            if (stall) begin
              // Decode is full: park the accepted word so it is not lost
              skid_d       = imem_rdata;
              skid_pc4_d   = pc_inc;
              skid_valid_d = 1'b1;
              state_d      = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!stall) begin
            // Memory not ready and decode is draining: insert a bubble
            ifid_flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_load    = skid_valid_q;
            ifid_instr   = skid_q;
            ifid_pc4     = skid_pc4_q;
            skid_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // FSM, PC and skid buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      skid_q       <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr),
    .pc4_i   (ifid_pc4),
    .instr_o (if_instr),
    .pc4_o   (if_pc4),
    .valid_o (if_valid)
  );

  // Request decoded from registered state only
  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;

  assign opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = if_instr[RS_MSB:RS_LSB];
  assign rt     = if_instr[RT_MSB:RT_LSB];
  assign rd     = if_instr[RD_MSB:RD_LSB];
  assign funct  = if_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm    = if_instr[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        reset2;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_ready;
  logic        w_stall;
  logic        w_branch;
  logic [31:0] w_target;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h8C22_0004;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_ready(w_ready), .stall(w_stall),
    .branch_taken(w_branch), .branch_target(w_target),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc4(w_pc4),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct), .imm(w_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    imem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    w_ready = 1'b1; w_stall = 1'b0; w_branch = 1'b0; w_target = 32'h0;

    #2;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);

    step();
    reset = 1'b0;
    #1;
    chk("boot_req", {31'b0, imem_req}, 32'h0);

    step();  // BOOT -> FETCH
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, if_valid}, 32'h0);

    step();  // accept 0x0
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_instr0", if_instr, 32'hC0DE_0000);
    chk("seq_pc4_0", if_pc4, 32'h4);
    chk("seq_valid0", {31'b0, if_valid}, 32'h1);

    step();  // accept 0x4
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_instr4", if_instr, 32'h8C22_0004);
    chk("lw_opcode", {26'b0, opcode}, 32'h23);
    chk("lw_rs", {27'b0, rs}, 32'h1);
    chk("lw_rt", {27'b0, rt}, 32'h2);
    chk("lw_imm", {16'b0, imm}, 32'h4);
    chk("lw_funct", {26'b0, funct}, 32'h4);

    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_valid", {31'b0, if_valid}, 32'h0);
    end
    imem_ready = 1'b1;

    step();  // accept 0x8
    chk("resume_instr8", if_instr, 32'hC0DE_0008);
    chk("resume_valid", {31'b0, if_valid}, 32'h1);
    chk("resume_addrC", imem_addr, 32'hC);

    step();  // accept 0xC
    chk("seq_instrC", if_instr, 32'hC0DE_000C);
    chk("seq_addr10", imem_addr, 32'h10);

    stall = 1'b1;
    step();  // accept 0x10 into skid, HOLD
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_instr", if_instr, 32'hC0DE_000C);
    chk("hold_valid", {31'b0, if_valid}, 32'h1);
    chk("hold_addr", imem_addr, 32'h14);

    step();
    chk("hold2_req", {31'b0, imem_req}, 32'h0);
    chk("hold2_instr", if_instr, 32'hC0DE_000C);

    stall = 1'b0;
    step();  // skid -> IF/ID
    chk("skid_instr", if_instr, 32'hC0DE_0010);
    chk("skid_pc4", if_pc4, 32'h14);
    chk("skid_req", {31'b0, imem_req}, 32'h1);
    chk("skid_addr", imem_addr, 32'h14);

    step();  // accept 0x14
    chk("after_skid_instr", if_instr, 32'hC0DE_0014);
    chk("after_skid_addr", imem_addr, 32'h18);

    stall = 1'b1;
    step();  // 0x18 into skid, HOLD
    chk("br_pre_req", {31'b0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    step();  // redirect
    branch_taken = 1'b0; stall = 1'b0;
    chk("br_addr", imem_addr, 32'h40);
    chk("br_req", {31'b0, imem_req}, 32'h1);
    chk("br_valid", {31'b0, if_valid}, 32'h0);

    step();  // accept 0x40
    chk("br_instr", if_instr, 32'hC0DE_0040);
    chk("br_valid2", {31'b0, if_valid}, 32'h1);
    chk("br_pc4", if_pc4, 32'h44);

    stall = 1'b1;
    step();  // 0x44 into skid, HOLD
    chk("rst_hold_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_pc4", if_pc4, 32'h0);
    stall = 1'b0;
    step();
    reset = 1'b0;
    step();  // BOOT -> FETCH
    chk("rel_req", {31'b0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    step();
    chk("rel_instr", if_instr, 32'hC0DE_0000);
    chk("rel_valid", {31'b0, if_valid}, 32'h1);

    reset2 = 1'b0;
    step();  // BOOT -> FETCH
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    chk("wrap_req", {31'b0, w_req}, 32'h1);
    step();
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", w_pc4, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", w_addr, 32'h0);
    chk("wrap_pc4_2", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, 32'hC0DE_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
